// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order reorder buffer with out-of-order writeback
// Single-port alloc, by-slot writeback, in-order retire, two combinational forwarding ports.
module reorder_buffer #(
  parameter int DEPTH  = 32,
  parameter int SLOT_W = 7
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alloc_req,
  input  logic [4:0]        alloc_dest_reg,
  input  logic              alloc_dest_valid,
  output logic              alloc_ready,
  output logic [SLOT_W-1:0] alloc_slot,
  input  logic              wb_valid,
  input  logic [SLOT_W-1:0] wb_slot,
  input  logic [31:0]       wb_result_hi,
  input  logic [31:0]       wb_result_lo,
  output logic              retire_valid,
  input  logic              retire_ready,
  output logic [4:0]        retire_dest_reg,
  output logic              retire_dest_valid,
  output logic [31:0]       retire_result_hi,
  output logic [31:0]       retire_result_lo,
  input  logic              flush,
  input  logic [SLOT_W-1:0] rd_slot_a,
  input  logic [SLOT_W-1:0] rd_slot_b,
  output logic              rd_a_done,
  output logic              rd_b_done,
  output logic [31:0]       rd_a_data,
  output logic [31:0]       rd_b_data,
  output logic [7:0]        count,
  output logic              empty
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [SLOT_W-1:0] MAX_SLOT = SLOT_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] WRAP_ONLY = {1'b1, {IDX_W{1'b0}}};

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, occ;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, dest_valid_q, dest_valid_d;
  logic [4:0]       dest_reg_q [DEPTH];
  logic [4:0]       dest_reg_d [DEPTH];
  logic [31:0]      hi_q [DEPTH];
  logic [31:0]      hi_d [DEPTH];
  logic [31:0]      lo_q [DEPTH];
  logic [31:0]      lo_d [DEPTH];

  logic [IDX_W-1:0] head_idx, tail_idx, wb_idx;
  logic full, wb_ok, retire_fire, alloc_fire;

  assign head_idx    = head_q[IDX_W-1:0];
  assign tail_idx    = tail_q[IDX_W-1:0];
  assign wb_idx      = wb_slot[IDX_W-1:0];
  assign wb_ok       = wb_valid && (wb_slot <= MAX_SLOT);
  assign full        = (head_q ^ tail_q) == WRAP_ONLY;
  assign empty       = head_q == tail_q;
  assign occ         = tail_q - head_q;
  assign count       = 8'(occ);
  assign alloc_ready = !full;
  assign alloc_slot  = SLOT_W'(tail_idx);
  assign alloc_fire  = alloc_req && alloc_ready;

  assign retire_valid      = !flush && valid_q[head_idx] && done_q[head_idx];
  assign retire_fire       = retire_valid && retire_ready;
  assign retire_dest_reg   = retire_valid ? dest_reg_q[head_idx] : 5'd0;
  assign retire_dest_valid = retire_valid && dest_valid_q[head_idx];
  assign retire_result_hi  = retire_valid ? hi_q[head_idx] : 32'd0;
  assign retire_result_lo  = retire_valid ? lo_q[head_idx] : 32'd0;

  // A lookup of a slot being written back this cycle sees the incoming result.
  function automatic logic [32:0] fwd(input logic [SLOT_W-1:0] slot);
    logic [IDX_W-1:0] idx;
    logic bypass, hit;
    idx    = slot[IDX_W-1:0];
    bypass = wb_ok && (wb_slot == slot);
    hit    = (slot <= MAX_SLOT) && valid_q[idx] && (done_q[idx] || bypass);
    if (!hit)       return 33'd0;
    else if (bypass) return {1'b1, wb_result_lo};
    else             return {1'b1, lo_q[idx]};
  endfunction

  assign {rd_a_done, rd_a_data} = fwd(rd_slot_a);
  assign {rd_b_done, rd_b_data} = fwd(rd_slot_b);

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    valid_d      = valid_q;
    done_d       = done_q;
    dest_valid_d = dest_valid_q;
    dest_reg_d   = dest_reg_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      valid_d = '0;
      done_d  = '0;
    end else begin
      if (wb_ok && valid_q[wb_idx]) begin
        done_d[wb_idx] = 1'b1;
        hi_d[wb_idx]   = wb_result_hi;
        lo_d[wb_idx]   = wb_result_lo;
      end
      if (retire_fire) begin
        valid_d[head_idx] = 1'b0;
        done_d[head_idx]  = 1'b0;
        head_d            = head_q + 1'b1;
      end
      // Not full, so the tail slot is never the head slot being retired.
      if (alloc_fire) begin
        valid_d[tail_idx]      = 1'b1;
        done_d[tail_idx]       = 1'b0;
        dest_reg_d[tail_idx]   = alloc_dest_reg;
        dest_valid_d[tail_idx] = alloc_dest_valid;
        tail_d                 = tail_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q       <= '0;
      tail_q       <= '0;
      valid_q      <= '0;
      done_q       <= '0;
      dest_valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_reg_q[i] <= '0;
        hi_q[i]       <= '0;
        lo_q[i]       <= '0;
      end
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      dest_valid_q <= dest_valid_d;
      dest_reg_q   <= dest_reg_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end
endmodule
